sram_1w1r_bypass: RTL and testbench

//  Single-clock 1-write/1-read SRAM. Successor to the dual-clock XPM 1W1R wrapper, for blocks on one clock domain.

---
 rtl/sram_1w1r_bypass.sv | 138 +++++++++++++
 tb/tb_sram_1w1r_bypass.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1w1r_bypass.sv
// rtl/sram_1w1r_bypass.sv - single-clock 1W1R SRAM with lane mask, bypass and 1/2-cycle read latency
//
// Purpose
//   Single-clock-domain 1-write/1-read memory for line buffers and CNN
//   feature/weight stores. Lane-masked writes, write-first read bypass,
//   out-of-range protection, read latency of 1 or 2 with a valid strobe.
//   Storage is a plain array with no reset so synthesis can map it to
//   block or distributed RAM.
//
// Ports
//   clk     in   1      clock, rising edge
//   rstn    in   1      asynchronous active-low reset (pipeline only)
//   qa      out  WWORD  read data; holds the last result while idle
//   qa_vld  out  1      high in the cycle qa carries a fresh read result
//   aa      in   WADDR  read address
//   cena    in   1      read enable, active-low
//   db      in   WWORD  write data
//   ab      in   WADDR  write address
//   cenb    in   1      write enable, active-low
//   wlane   in   NLANE  per-lane write mask, active-high, lane 0 = LSBs

module sram_1w1r_bypass #(
  parameter int WWORD    = 32,
  parameter int WADDR    = 5,
  parameter int DEPTH    = 24,
  parameter int NLANE    = 1,
  parameter int READ_LAT = 1
) (
  input  logic             clk,
  input  logic             rstn,
  output logic [WWORD-1:0] qa,
  output logic             qa_vld,
  input  logic [WADDR-1:0] aa,
  input  logic             cena,
  input  logic [WWORD-1:0] db,
  input  logic [WADDR-1:0] ab,
  input  logic             cenb,
  input  logic [NLANE-1:0] wlane
);

  localparam int LW = WWORD / NLANE;

  // Elaboration-time parameter guards.
  generate
    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
      $error("sram_1w1r_bypass: READ_LAT must be 1 or 2");
    end
    if ((WWORD % NLANE) != 0) begin : g_bad_lane
      $error("sram_1w1r_bypass: WWORD must be a multiple of NLANE");
    end
    if (DEPTH < 1 || DEPTH > (1 << WADDR)) begin : g_bad_depth
      $error("sram_1w1r_bypass: DEPTH out of range for WADDR");
    end
  endgenerate

  // Depth as a WADDR+1 bit value so DEPTH == 2**WADDR still compares correctly.
  localparam int unsigned DEPTH_U = DEPTH;
  localparam logic [WADDR:0] DEPTH_W = DEPTH_U[WADDR:0];

  logic [WWORD-1:0] mem [0:DEPTH-1];

  logic             wr_ok;
  logic             rd_ok;
  logic [WWORD-1:0] rd_d;

  logic [WWORD-1:0] s1_q;
  logic             v1_q;

  assign wr_ok = !cenb && ({1'b0, ab} < DEPTH_W);
  assign rd_ok = {1'b0, aa} < DEPTH_W;

  // Storage: no reset so contents survive rstn and RAM inference is kept.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < NLANE; i++) begin
        if (wlane[i]) begin
          mem[ab][i*LW +: LW] <= db[i*LW +: LW];
        end
      end
    end
  end

  // Read result as the word will stand after this edge's write (write-first):
  // lanes being written to the same address come straight from db.
  always_comb begin
    rd_d = '0;
    if (rd_ok) begin
      rd_d = mem[aa];
      if (!cenb && (ab == aa)) begin
        for (int i = 0; i < NLANE; i++) begin
          if (wlane[i]) begin
            rd_d[i*LW +: LW] = db[i*LW +: LW];
          end
        end
      end
    end
  end

  // First output stage: captured only on a read so idle cycles hold qa.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= !cena;
      if (!cena) begin
        s1_q <= rd_d;
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [WWORD-1:0] s2_q;
      logic             v2_q;

      // Second stage follows the valid of stage one so it also holds when idle.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          s2_q <= '0;
          v2_q <= 1'b0;
        end else begin
          v2_q <= v1_q;
          if (v1_q) begin
            s2_q <= s1_q;
          end
        end
      end

      assign qa     = s2_q;
      assign qa_vld = v2_q;
    end else begin : g_lat1
      assign qa     = s1_q;
      assign qa_vld = v1_q;
    end
  endgenerate

endmodule

// File: tb/tb_sram_1w1r_bypass.sv
// tb/tb_sram_1w1r_bypass.sv - self-checking bench for sram_1w1r_bypass (latency 1 and 2)

module tb_sram_1w1r_bypass;

  logic        clk;
  logic        rstn;
  logic [4:0]  aa;
  logic        cena;
  logic [31:0] db;
  logic [4:0]  ab;
  logic        cenb;
  logic [3:0]  wlane;

  logic [31:0] qa1, qa2;
  logic        qa_vld1, qa_vld2;

  sram_1w1r_bypass #(.WWORD(32), .WADDR(5), .DEPTH(24), .NLANE(4), .READ_LAT(1)) u_lat1 (
    .clk(clk), .rstn(rstn), .qa(qa1), .qa_vld(qa_vld1),
    .aa(aa), .cena(cena), .db(db), .ab(ab), .cenb(cenb), .wlane(wlane)
  );

  sram_1w1r_bypass #(.WWORD(32), .WADDR(5), .DEPTH(24), .NLANE(4), .READ_LAT(2)) u_lat2 (
    .clk(clk), .rstn(rstn), .qa(qa2), .qa_vld(qa_vld2),
    .aa(aa), .cena(cena), .db(db), .ab(ab), .cenb(cenb), .wlane(wlane)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: word memory, plus per-edge record of issued reads and their results.
  logic [31:0] mdl [0:23];
  bit          iss [0:4095];
  logic [31:0] rdv [0:4095];
  int          edge_n = 0;
  int          flush_edge = 0;
  logic [31:0] hold1 = '0;
  logic [31:0] hold2 = '0;
  bit          chk_en = 0;

  always @(posedge clk) begin
    logic [31:0] r;
    edge_n = edge_n + 1;
    if (edge_n < 4096) begin
      if (rstn) begin
        if (!cenb && ab < 5'd24)
          for (int i = 0; i < 4; i++)
            if (wlane[i]) mdl[ab][i*8 +: 8] = db[i*8 +: 8];
        r = (aa < 5'd24) ? mdl[aa] : 32'h0;
        iss[edge_n] = !cena;
        rdv[edge_n] = r;
      end else begin
        iss[edge_n] = 1'b0;
      end
    end
  end

  always @(negedge rstn) begin
    flush_edge = edge_n;
    hold1 = '0;
    hold2 = '0;
  end

  // A read sampled at edge s shows at the output after edge s+L-1.
  always @(negedge clk) begin
    int s;
    bit ev;
    if (chk_en) begin
      s  = edge_n;
      ev = (s > flush_edge) && (s >= 1) && iss[s];
      if (ev) hold1 = rdv[s];
      chk("cmp_vld_lat1", {31'b0, qa_vld1}, {31'b0, ev});
      chk("cmp_qa_lat1", qa1, hold1);
      s  = edge_n - 1;
      ev = (s > flush_edge) && (s >= 1) && iss[s];
      if (ev) hold2 = rdv[s];
      chk("cmp_vld_lat2", {31'b0, qa_vld2}, {31'b0, ev});
      chk("cmp_qa_lat2", qa2, hold2);
    end
  end

  task automatic cyc(input logic rd_en, input logic [4:0] ra, input logic wr_en,
                     input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] wl);
    cena  = !rd_en;
    aa    = ra;
    cenb  = !wr_en;
    ab    = wa;
    db    = wd;
    wlane = wl;
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] wl);
    cyc(1'b0, 5'd0, 1'b1, a, d, wl);
  endtask

  task automatic rd(input logic [4:0] a);
    cyc(1'b1, a, 1'b0, 5'd0, 32'h0, 4'h0);
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 4'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1, n2;
    rstn = 1'b1; cena = 1'b1; cenb = 1'b1; aa = '0; ab = '0; db = '0; wlane = '0;
    #2 rstn = 1'b0;
    chk_en = 1;
    @(negedge clk);
    chk("reset_qa1", qa1, 32'h0);
    chk("reset_vld2", {31'b0, qa_vld2}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 24; i++) wr(i[4:0], 32'hA5A50000 ^ (i * 32'h01010101), 4'hF);

    // Latency
    wr(5'd3, 32'hDEADBEEF, 4'hF);
    rd(5'd3);
    chk("lat1_qa", qa1, 32'hDEADBEEF);
    chk("lat1_vld", {31'b0, qa_vld1}, 32'h1);
    chk("lat2_not_yet", {31'b0, qa_vld2}, 32'h0);
    idle();
    chk("lat2_qa", qa2, 32'hDEADBEEF);
    chk("lat2_vld", {31'b0, qa_vld2}, 32'h1);
    chk("lat1_vld_gone", {31'b0, qa_vld1}, 32'h0);

    // Out-of-range write, then back-to-back sweep
    wr(5'd30, 32'hFFFFFFFF, 4'hF);
    n1 = 0; n2 = 0;
    for (int i = 0; i < 24; i++) begin
      rd(i[4:0]);
      n1 += qa_vld1;
      n2 += qa_vld2;
      if (i == 3) chk("sweep_at3", qa1, 32'hDEADBEEF);
    end
    idle();
    n2 += qa_vld2;
    chk("sweep_cnt_lat1", n1, 24);
    chk("sweep_cnt_lat2", n2, 24);
    chk("sweep_last", qa2, 32'hA5A50000 ^ (23 * 32'h01010101));

    rd(5'd30);
    chk("oob_qa", qa1, 32'h0);
    chk("oob_vld", {31'b0, qa_vld1}, 32'h1);
    idle();

    // Lane mask
    wr(5'd5, 32'h11223344, 4'hF);
    wr(5'd5, 32'hAABBCCDD, 4'b0101);
    rd(5'd5);
    chk("lane_mask", qa1, 32'h11BB33DD);
    wr(5'd5, 32'hFFFFFFFF, 4'h0);
    rd(5'd5);
    chk("lane_noop", qa1, 32'h11BB33DD);

    // Collision and write-after-read
    wr(5'd7, 32'h00000000, 4'hF);
    cyc(1'b1, 5'd7, 1'b1, 5'd7, 32'h12345678, 4'hF);
    chk("bypass", qa1, 32'h12345678);
    rd(5'd7);
    chk("pre_war", qa1, 32'h12345678);
    wr(5'd7, 32'h55555555, 4'hF);
    chk("war_lat2", qa2, 32'h12345678);
    rd(5'd7);
    chk("war_new", qa1, 32'h55555555);

    // Hold
    wr(5'd9, 32'hCAFEF00D, 4'hF);
    rd(5'd9);
    idle();
    for (int i = 0; i < 10; i++) begin
      idle();
      chk("hold_qa1", qa1, 32'hCAFEF00D);
      chk("hold_qa2", qa2, 32'hCAFEF00D);
      chk("hold_vld", {30'b0, qa_vld1, qa_vld2}, 32'h0);
    end

    // Reset mid-stream with reads in flight
    rd(5'd1);
    rd(5'd2);
    cena = 1'b0; aa = 5'd3; cenb = 1'b1;
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_now_qa1", qa1, 32'h0);
    chk("rst_now_qa2", qa2, 32'h0);
    chk("rst_now_vld", {30'b0, qa_vld1, qa_vld2}, 32'h0);
    cena = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    n1 = 0;
    for (int i = 0; i < 3; i++) begin
      idle();
      n1 += qa_vld1 + qa_vld2;
    end
    chk("rst_no_vld", n1, 0);
    rd(5'd3);
    chk("rst_mem_kept1", qa1, 32'hDEADBEEF);
    idle();
    chk("rst_mem_kept2", qa2, 32'hDEADBEEF);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
